train_limit_regulator: RTL
==========================

Name: train_limit_regulator

Overview:
- Sits directly downstream of dropoff_train_station, between its L output and the train stop's train-limit input.
- Turns the raw, tick-by-tick requested limit into a rate-limited, hysteresis-filtered limit, so trains are not repeatedly called and released while the network total R settles.
- Detects train arrival and departure events from the stop's T signal and counts them.
- Provides a fast shut-off path when the station reports that it is full.

Parameters:
- Q, 3, maximum train limit ever driven; the same value as the station queue length.
- HOLD, 60, minimum number of clock ticks between two non-forced limit changes; must be 1 or more.
- CW, 16, width of the arrival and departure event counters.
- INT, 31, MSB index of signal-width ports; signal values are 32-bit two's complement.

Ports:
- clk, input, 1, game-tick clock.
- rst, input, 1, synchronous reset, active-high.
- l, input, INT+1, requested limit L from dropoff_train_station.
- c, input, INT+1, trains en route or present (train stop C).
- t, input, INT+1, ID of the train at the stop (train stop T); 0 means empty.
- k, output, INT+1, regulated limit driven to the train stop.
- busy, output, 1, high while the hold timer is running.
- arr, output, CW, arrival event count.
- dep, output, CW, departure event count.
- ovr, output, 1, sticky flag; set when c > k is sampled while idle.

Behaviour:
- All outputs reset to 0. Internal state resets to IDLE, timer 0, l_q = 0, t_q = 0. A reset asserted mid-hold abandons the hold; the block is IDLE on the cycle after rst deasserts.
- Input stage: l, c and t are registered every cycle into l_q, c_q and t_q.
- Target: tgt = 0 if l_q is negative (signed), Q if l_q > Q, otherwise l_q. Computed combinationally from l_q.
- State IDLE:
  - If tgt == k: no change.
  - If tgt > k: set k = k+1, timer = HOLD-1, go to HOLD.
  - If tgt < k: set k = k-1, timer = HOLD-1, go to HOLD.
- State HOLD:
  - timer decrements by 1 each cycle.
  - When timer == 0 on a clock edge, go to IDLE. k stays unchanged throughout HOLD.
  - If HOLD == 1, the block stays in HOLD for exactly one cycle.
- Forced off:
  - Applies in any state: if tgt == 0 and k != 0, k goes to 0 on the next edge, state goes to IDLE and timer is cleared.
  - Forced off takes priority over the hold and over stepping.
  - Forced off does not start a hold, so a later rise is not delayed.
- Latency: a change on l reaches k on the 2nd rising edge after l changes (1 cycle input register plus 1 decision cycle), provided the block is IDLE.
- Step rule: k moves by at most 1 per HOLD window. Going from 0 to Q therefore takes (Q-1)*HOLD + 2 cycles. k is always in the range 0..Q.
- busy = (state == HOLD).
- Event detection, evaluated on t against the previous registered value (t_q against t_q_prev, one extra register):
  - 0 to nonzero: arrival, arr increments by 1.
  - nonzero to 0: departure, dep increments by 1.
  - nonzero to a different nonzero in one cycle: both counters increment by 1 in the same cycle.
  - Counters wrap modulo 2^CW with no saturation.
- ovr: set on any IDLE cycle where signed c_q > k. Cleared only by rst. It is informational only and does not affect k.
- Arithmetic: comparisons on l, c and t are signed 32-bit. k is stored using the minimum width needed for Q and zero-extended onto the port.

Decomposition:
- Shared package train_balancer_pkg:
  - typedef sig_t (signed [31:0]).
  - enum reg_state_e {IDLE, HOLD}.
  - constant SIG_W = 32.
- One sub-module, train_event_detector: handles t_q_prev and the arr/dep counters. This logic is independent of the limit FSM and is reused by the future pickup station.
- The FSM, timer and target clamp stay in the top level.

Test Plan:
- Reset, then l = 3 held with Q = 3 and HOLD = 4 → k = 1 at edge 2, k = 2 at edge 6, k = 3 at edge 10; busy is high during each 4-cycle window.
- k = 3, IDLE, then l = 0 → k = 0 at edge 2. Then l = 2 on the very next cycle → k = 1 two edges later with no hold delay.
- l = -5, then l = 99 → k stays 0 for l = -5; k steps up toward 3 and never exceeds 3 for l = 99.
- t sequence 0, 7, 7, 0, 9, 12 → arr = 3, dep = 2. Then preload 2^16 - 1 arrivals → arr wraps to 0.
- Mid-hold (k = 1, timer = 2), assert rst for 1 cycle with l = 3 → k = 0 and busy = 0; k = 1 on the 2nd edge after rst deasserts.
- k = 1 IDLE with c = 3 → ovr = 1 next cycle; ovr stays 1 after c returns to 0, until rst.

Source files
------------

// File: rtl/train_balancer_pkg.sv
// Shared types and constants for the train balancing blocks (station regulator,
// event detection and the future pickup station).
package train_balancer_pkg;

    localparam int SIG_W = 32;

    typedef logic signed [SIG_W-1:0] sig_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } reg_state_e;

endpackage

// File: rtl/train_event_detector.sv
// Counts train arrivals and departures from the registered train-stop T signal.
// A direct swap of one train ID for another counts as both events.
module train_event_detector
    import train_balancer_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  sig_t          t,
    output logic [CW-1:0] arr,
    output logic [CW-1:0] dep
);

    sig_t          t_prev_r;
    logic [CW-1:0] arr_r;
    logic [CW-1:0] dep_r;
    logic          changed_s;
    logic          arr_inc_s;
    logic          dep_inc_s;

    // Edge classification of the current T against the previous sample
    always_comb begin
        changed_s = 1'b0;
        arr_inc_s = 1'b0;
        dep_inc_s = 1'b0;
        if (t != t_prev_r) begin
            changed_s = 1'b1;
            arr_inc_s = (t != 32'sd0);
            dep_inc_s = (t_prev_r != 32'sd0);
        end else begin
            changed_s = 1'b0;
        end
    end

    // Previous-sample register and wrapping event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            t_prev_r <= 32'sd0;
            arr_r    <= {CW{1'b0}};
            dep_r    <= {CW{1'b0}};
        end else begin
            t_prev_r <= t;
            if (changed_s && arr_inc_s) begin
                arr_r <= arr_r + CW'(1);
            end else begin
                arr_r <= arr_r;
            end
            if (changed_s && dep_inc_s) begin
                dep_r <= dep_r + CW'(1);
            end else begin
                dep_r <= dep_r;
            end
        end
    end

    assign arr = arr_r;
    assign dep = dep_r;

endmodule

// File: rtl/train_limit_regulator.sv
// Rate-limited, hysteresis-filtered train limit for a dropoff station, with a
// fast shut-off path and arrival/departure counting.
module train_limit_regulator #(
    parameter int Q    = 3,
    parameter int HOLD = 60,
    parameter int CW   = 16,
    parameter int INT  = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [INT:0]  l,
    input  logic [INT:0]  c,
    input  logic [INT:0]  t,
    output logic [INT:0]  k,
    output logic          busy,
    output logic [CW-1:0] arr,
    output logic [CW-1:0] dep,
    output logic          ovr
);

    import train_balancer_pkg::sig_t;

    localparam int KW = $clog2(Q + 1);
    localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [KW-1:0]       K_MAX    = KW'(Q);
    localparam logic [TW-1:0]       T_LOAD   = TW'(HOLD - 1);
    localparam logic signed [INT:0] Q_S      = $signed((INT + 1)'(Q));
    localparam logic [0:0]          ST_IDLE  = train_balancer_pkg::IDLE;
    localparam logic [0:0]          ST_HOLD  = train_balancer_pkg::HOLD;

    logic signed [INT:0] l_r;
    logic signed [INT:0] c_r;
    sig_t                t_r;
    logic [0:0]          state_r;
    logic [TW-1:0]       timer_r;
    logic [KW-1:0]       k_r;
    logic                busy_r;
    logic                ovr_r;

    logic [KW-1:0]       tgt_s;
    logic signed [INT:0] k_ext_s;
    logic                step_s;
    logic [0:0]          state_n_s;
    logic [TW-1:0]       timer_n_s;
    logic [KW-1:0]       k_n_s;

    // Clamp the registered request into the drivable range 0..Q
    always_comb begin
        tgt_s = {KW{1'b0}};
        if (l_r[INT]) begin
            tgt_s = {KW{1'b0}};
        end else if (l_r > Q_S) begin
            tgt_s = K_MAX;
        end else begin
            tgt_s = l_r[KW-1:0];
        end
    end

    assign k_ext_s = $signed({{(INT + 1 - KW){1'b0}}, k_r});

    // The last hold cycle doubles as a decision cycle, so steps are HOLD ticks apart
    assign step_s = (state_r == ST_IDLE) || (timer_r == {TW{1'b0}});

    // Next-state decision: shut-off first, then the hold countdown, then stepping
    always_comb begin
        state_n_s = state_r;
        timer_n_s = timer_r;
        k_n_s     = k_r;
        if ((tgt_s == {KW{1'b0}}) && (k_r != {KW{1'b0}})) begin
            k_n_s     = {KW{1'b0}};
            state_n_s = ST_IDLE;
            timer_n_s = {TW{1'b0}};
        end else if (!step_s) begin
            timer_n_s = timer_r - TW'(1);
        end else if (tgt_s > k_r) begin
            k_n_s     = k_r + KW'(1);
            state_n_s = ST_HOLD;
            timer_n_s = T_LOAD;
        end else if (tgt_s < k_r) begin
            k_n_s     = k_r - KW'(1);
            state_n_s = ST_HOLD;
            timer_n_s = T_LOAD;
        end else begin
            state_n_s = ST_IDLE;
            timer_n_s = {TW{1'b0}};
        end
    end

    // Input stage, limit FSM state and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            l_r     <= {(INT + 1){1'b0}};
            c_r     <= {(INT + 1){1'b0}};
            t_r     <= 32'sd0;
            state_r <= ST_IDLE;
            timer_r <= {TW{1'b0}};
            k_r     <= {KW{1'b0}};
            busy_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            l_r     <= $signed(l);
            c_r     <= $signed(c);
            t_r     <= $signed(t);
            state_r <= state_n_s;
            timer_r <= timer_n_s;
            k_r     <= k_n_s;
            busy_r  <= (state_n_s == ST_HOLD);
            if ((state_r == ST_IDLE) && (c_r > k_ext_s)) begin
                ovr_r <= 1'b1;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

    train_event_detector #(
        .CW (CW)
    ) u_event_detector (
        .clk (clk),
        .rst (rst),
        .t   (t_r),
        .arr (arr),
        .dep (dep)
    );

    assign k    = {{(INT + 1 - KW){1'b0}}, k_r};
    assign busy = busy_r;
    assign ovr  = ovr_r;

endmodule
